// File: rtl/uart_image_loader.sv
// UART 8N1 receiver and frame-load FSM that writes one image into the pooling input BRAM.
// Optional inter-byte timeout, with a timeout_pulse port, when RX_TIMEOUT_EN is defined.
module uart_image_loader #(
   parameter int unsigned CLKS_PER_BIT   = 868,
   parameter int unsigned NUM_PIXELS     = 4096,
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic              actual_clock,
   input  logic              reset,
   input  logic              rx,
   input  logic              arm,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              start_pooling,
   output logic              busy,
   output logic              load_done,
   output logic              frame_error,
   output logic [ADDR_W:0]   byte_count
`ifdef RX_TIMEOUT_EN
   ,
   output logic              timeout_pulse
`endif
);

   localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CNT1_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_END = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT1_W-1:0] LAST_IDX = CNT1_W'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
   typedef enum logic [1:0] {L_IDLE, L_RECV, L_WRITE, L_DONE} ld_state_e;

   rx_state_e        rx_state_q, rx_state_d;
   ld_state_e        ld_state_q, ld_state_d;
   logic             rx_meta_q, rxs_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [2:0]       rx_bit_q;
   logic [7:0]       rx_shift_q;
   logic             stop_wait_q, byte_valid_q;
   logic             rx_tick, byte_done, stop_bad;

   logic [CNT1_W-1:0] byte_count_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              start_pooling_q, load_done_q, frame_error_q;
   logic              to_hit;

   // Synchronizer flops reset to the idle-high line level.
   always_ff @(posedge actual_clock or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
      end
   end

   always_ff @(posedge actual_clock or posedge reset) begin
      if (reset) rx_state_q <= R_IDLE;
      else       rx_state_q <= rx_state_d;
   end

   always_comb begin
      rx_tick    = 1'b0;
      rx_state_d = rx_state_q;
      unique case (rx_state_q)
         R_IDLE: if (!rxs_q) rx_state_d = R_START;
         R_START: begin
            rx_tick = (rx_cnt_q == HALF_END);
            if (rx_tick) rx_state_d = rxs_q ? R_IDLE : R_DATA;
         end
         R_DATA: begin
            rx_tick = (rx_cnt_q == BIT_END);
            if (rx_tick && rx_bit_q == 3'd7) rx_state_d = R_STOP;
         end
         R_STOP: begin
            rx_tick = (rx_cnt_q == BIT_END);
            if ((rx_tick || stop_wait_q) && rxs_q) rx_state_d = R_IDLE;
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      byte_done = (rx_state_q == R_STOP) && rx_tick && !stop_wait_q && rxs_q;
      stop_bad  = (rx_state_q == R_STOP) && rx_tick && !stop_wait_q && !rxs_q;
   end

   // After a bad stop bit the counter is frozen until the line returns high.
   always_ff @(posedge actual_clock or posedge reset) begin
      if (reset) begin
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         stop_wait_q  <= 1'b0;
         byte_valid_q <= 1'b0;
      end else begin
         byte_valid_q <= byte_done;
         if (rx_state_q == R_IDLE || rx_tick || stop_wait_q) rx_cnt_q <= '0;
         else rx_cnt_q <= rx_cnt_q + CNT_W'(1);
         if (rx_state_q == R_IDLE) begin
            rx_bit_q    <= '0;
            stop_wait_q <= 1'b0;
         end
         if (rx_state_q == R_DATA && rx_tick) begin
            rx_shift_q <= {rxs_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
         end
         if (stop_bad) stop_wait_q <= 1'b1;
      end
   end

   always_ff @(posedge actual_clock or posedge reset) begin
      if (reset) ld_state_q <= L_IDLE;
      else       ld_state_q <= ld_state_d;
   end

   always_comb begin
      ld_state_d = ld_state_q;
      unique case (ld_state_q)
         L_IDLE, L_DONE: if (arm) ld_state_d = L_RECV;
         L_RECV:  if (byte_valid_q) ld_state_d = L_WRITE;
         L_WRITE: ld_state_d = (byte_count_q == LAST_IDX) ? L_DONE : L_RECV;
         default: ld_state_d = L_IDLE;
      endcase
   end

   always_comb begin
      busy  = (ld_state_q == L_RECV) || (ld_state_q == L_WRITE);
      wr_en = (ld_state_q == L_WRITE);
   end

`ifdef RX_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;

   assign to_hit = (ld_state_q == L_RECV) && (byte_count_q != '0) && !byte_valid_q &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
   assign timeout_pulse = to_hit;

   always_ff @(posedge actual_clock or posedge reset) begin
      if (reset) to_cnt_q <= '0;
      else if (ld_state_q != L_RECV || byte_valid_q || to_hit || byte_count_q == '0)
         to_cnt_q <= '0;
      else to_cnt_q <= to_cnt_q + TO_W'(1);
   end
`else
   logic unused_timeout;
   assign to_hit         = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge actual_clock or posedge reset) begin
      if (reset) begin
         byte_count_q    <= '0;
         wr_addr_q       <= '0;
         wr_data_q       <= '0;
         start_pooling_q <= 1'b0;
         load_done_q     <= 1'b0;
         frame_error_q   <= 1'b0;
      end else begin
         start_pooling_q <= (ld_state_q == L_WRITE) && (ld_state_d == L_DONE);
         if ((ld_state_q == L_IDLE || ld_state_q == L_DONE) && arm) begin
            byte_count_q  <= '0;
            load_done_q   <= 1'b0;
            frame_error_q <= 1'b0;
         end
         if (stop_bad) frame_error_q <= 1'b1;
         if (ld_state_q == L_RECV && byte_valid_q) begin
            wr_data_q <= rx_shift_q;
            wr_addr_q <= byte_count_q[ADDR_W-1:0];
         end
         if (ld_state_q == L_WRITE) begin
            byte_count_q <= byte_count_q + CNT1_W'(1);
            if (ld_state_d == L_DONE) load_done_q <= 1'b1;
         end
         if (to_hit) byte_count_q <= '0;
      end
   end

   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign start_pooling = start_pooling_q;
   assign load_done     = load_done_q;
   assign frame_error   = frame_error_q;
   assign byte_count    = byte_count_q;

endmodule
